mips_multicycle_ctrl: RTL and testbench

Multicycle MIPS control unit that sequences each instruction through fetch/decode/execute/memory/writeback states. It drives the datapath muxes and enables, and generates the 3-bit `alucontrol` code consumed directly by the ALU stage. It also takes the ALU `zero` flag back to resolve branches. It replaces the single-cycle main decoder when the datapath moves to a shared instruction/data memory.

---
 rtl/mips_multicycle_ctrl.sv | 159 +++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM with ALU function decode
module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     state_q;
    state_t     state_d;
    logic       pcwrite;
    logic       branch;
    logic [1:0] aluop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            // Terminal states and the unused codes 12-15 all return to fetch.
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pcwrite  = 1'b0;
        branch   = 1'b0;
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = 2'b00;
        case (state_q)
            S_FETCH: begin
                irwrite = 1'b1;
                pcwrite = 1'b1;
                alusrcb = 2'b01;
            end
            S_DECODE:  alusrcb = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD:   iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIWB:  regwrite = 1'b1;
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Unlisted R-type functs map to 011, which the ALU resolves to a zero result.
    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            2'b01: alucontrol = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b011;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

    assign pcen  = pcwrite | (branch & zero);
    assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - directed bench with a per-cycle reference model of the control unit
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       irwrite, pcwrite, branch, iord, memwrite, regdst, memtoreg, regwrite, alusrca;
        logic [1:0] alusrcb, pcsrc, aluop;
    } ctl_t;

    int   checks = 0;
    int   errors = 0;
    int   exp_state = 0;
    bit   check_en = 1'b0;
    ctl_t row;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Output table as listed for each named state.
    function automatic ctl_t spec_row(input int s);
        ctl_t r = '0;
        if (s == 0) begin r.irwrite = 1; r.pcwrite = 1; r.alusrcb = 2'b01; end
        if (s == 1) r.alusrcb = 2'b11;
        if (s == 2 || s == 9) begin r.alusrca = 1; r.alusrcb = 2'b10; end
        if (s == 3) r.iord = 1;
        if (s == 4) begin r.memtoreg = 1; r.regwrite = 1; end
        if (s == 5) begin r.iord = 1; r.memwrite = 1; end
        if (s == 6) begin r.alusrca = 1; r.aluop = 2'b10; end
        if (s == 7) begin r.regdst = 1; r.regwrite = 1; end
        if (s == 8) begin r.alusrca = 1; r.aluop = 2'b01; r.pcsrc = 2'b01; r.branch = 1; end
        if (s == 10) r.regwrite = 1;
        if (s == 11) begin r.pcsrc = 2'b10; r.pcwrite = 1; end
        return r;
    endfunction

    function automatic logic [2:0] alu_ref(input logic [1:0] aluop, input logic [5:0] f);
        logic [5:0] fl [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [2:0] cl [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        if (aluop == 2'b01) return 3'b110;
        if (aluop != 2'b10) return 3'b010;
        for (int i = 0; i < 5; i++) if (fl[i] == f) return cl[i];
        return 3'b011;
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            row = spec_row(exp_state);
            chk("state",      32'(state),      32'(exp_state));
            chk("pcen",       32'(pcen),       32'(row.pcwrite | (row.branch & zero)));
            chk("iord",       32'(iord),       32'(row.iord));
            chk("memwrite",   32'(memwrite),   32'(row.memwrite));
            chk("irwrite",    32'(irwrite),    32'(row.irwrite));
            chk("regdst",     32'(regdst),     32'(row.regdst));
            chk("memtoreg",   32'(memtoreg),   32'(row.memtoreg));
            chk("regwrite",   32'(regwrite),   32'(row.regwrite));
            chk("alusrca",    32'(alusrca),    32'(row.alusrca));
            chk("alusrcb",    32'(alusrcb),    32'(row.alusrcb));
            chk("pcsrc",      32'(pcsrc),      32'(row.pcsrc));
            chk("alucontrol", 32'(alucontrol), 32'(alu_ref(row.aluop, funct)));
        end
    end

    task automatic cycle(input int s);
        exp_state = s;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op_v, input logic [5:0] funct_v, input logic zero_v);
        int q[$];
        op = op_v; funct = funct_v; zero = zero_v;
        q = {0, 1};
        case (op_v)
            6'b100011: q = {q, 2, 3, 4};
            6'b101011: q = {q, 2, 5};
            6'b000000: q = {q, 6, 7};
            6'b000100: q.push_back(8);
            6'b001000: q = {q, 9, 10};
            6'b000010: q.push_back(11);
            default: ;
        endcase
        foreach (q[i]) begin
            cycle(q[i]);
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] rf [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        logic [2:0] rc [6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b011};

        rst_n = 1'b0; op = 6'b100011; funct = 6'b0; zero = 1'b1;
        exp_state = 0;
        check_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_irwrite", 32'(irwrite), 32'd1);
        chk("rst_pcen", 32'(pcen), 32'd1);
        chk("rst_alusrcb", 32'(alusrcb), 32'd1);
        chk("rst_alucontrol", 32'(alucontrol), 32'd2);
        chk("rst_regwrite", 32'(regwrite), 32'd0);
        rst_n = 1'b1;

        // lw straight out of reset, with zero held high outside any branch
        cycle(0); tick();
        chk("lw_after_release", 32'(state), 32'd1);
        cycle(1); tick();
        cycle(2); tick();
        cycle(3);
        chk("lw_memrd_iord", 32'(iord), 32'd1);
        tick();
        cycle(4);
        chk("lw_memwb_memtoreg", 32'(memtoreg), 32'd1);
        chk("lw_memwb_regwrite", 32'(regwrite), 32'd1);
        tick();

        run_instr(6'b101011, 6'b0, 1'b1);

        for (int i = 0; i < 6; i++) begin
            op = 6'b000000; funct = rf[i]; zero = 1'b0;
            cycle(0); tick();
            cycle(1); tick();
            cycle(6);
            chk("rtype_alucontrol", 32'(alucontrol), 32'(rc[i]));
            tick();
            cycle(7);
            chk("rtype_regdst", 32'(regdst), 32'd1);
            chk("rtype_regwrite", 32'(regwrite), 32'd1);
            tick();
        end

        for (int z = 1; z >= 0; z--) begin
            op = 6'b000100; funct = 6'b100101; zero = z[0];
            cycle(0); tick();
            cycle(1); tick();
            cycle(8);
            chk("beq_pcen", 32'(pcen), 32'(z));
            chk("beq_pcsrc", 32'(pcsrc), 32'd1);
            chk("beq_alucontrol", 32'(alucontrol), 32'd6);
            zero = ~zero;
            #1;
            chk("beq_pcen_follows_zero", 32'(pcen), 32'(1 - z));
            zero = z[0];
            tick();
        end

        op = 6'b000010; zero = 1'b0;
        cycle(0); tick();
        cycle(1); tick();
        cycle(11);
        chk("j_pcsrc", 32'(pcsrc), 32'd2);
        chk("j_pcen", 32'(pcen), 32'd1);
        tick();

        run_instr(6'b001000, 6'b101010, 1'b1);
        run_instr(6'b111111, 6'b100010, 1'b1);
        run_instr(6'b000001, 6'b000000, 1'b0);
        run_instr(6'b000000, 6'b111111, 1'b1);

        // asynchronous reset dropped in the middle of MEMRD
        op = 6'b100011; funct = 6'b0; zero = 1'b0;
        cycle(0); tick();
        cycle(1); tick();
        cycle(2); tick();
        cycle(3);
        #1;
        chk("midrst_iord_before", 32'(iord), 32'd1);
        rst_n = 1'b0;
        exp_state = 0;
        #1;
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_iord", 32'(iord), 32'd0);
        tick();
        rst_n = 1'b1;
        run_instr(6'b100011, 6'b0, 1'b0);
        run_instr(6'b101011, 6'b0, 1'b0);

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
